// File: rtl/link_ddr_downstream_multi.sv
// Multi-lane DDR downstream receiver: per-lane beat-pair gearbox and FIFO, joined core
// word with lock-step dequeue, and decimated credit tokens back upstream.
module link_ddr_downstream_multi #(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned CH_W        = 8,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned TOKEN_DECIM = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS-1:0]          io_valid_i,
  input  logic [CHANNELS*CH_W-1:0]     io_data_i,
  output logic                         core_valid_o,
  output logic [CHANNELS*2*CH_W-1:0]   core_data_o,
  input  logic                         core_yumi_i,
  output logic                         io_token_o,
  output logic [CHANNELS-1:0]          phase_o,
  output logic                         overflow_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;
  localparam int unsigned WW = 2 * CH_W;
  localparam int unsigned TW = (TOKEN_DECIM > 1) ? $clog2(TOKEN_DECIM) : 1;

  logic [CHANNELS-1:0] lane_empty;
  logic [CHANNELS-1:0] lane_drop;
  logic                pop;

  // Join is combinational from registered pointers; a pop is only honoured while valid.
  assign core_valid_o = ~|lane_empty;
  assign pop          = core_yumi_i & core_valid_o;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    logic            phase_q, phase_d;
    logic [CH_W-1:0] lo_q, lo_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [WW-1:0]   mem_q [DEPTH];
    logic [CH_W-1:0] beat;
    logic            push;
    logic            full;
    logic            wr_en;

    assign beat          = io_data_i[c*CH_W +: CH_W];
    assign full          = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign lane_empty[c] = (wptr_q == rptr_q);
    assign push          = io_valid_i[c] & phase_q;
    // A full lane still accepts the word when the same-cycle pop frees a slot.
    assign wr_en         = push & (~full | pop);
    assign lane_drop[c]  = push & full & ~pop;

    always_comb begin
      phase_d = phase_q;
      lo_d    = lo_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      if (io_valid_i[c]) begin
        phase_d = ~phase_q;
        if (!phase_q) lo_d = beat;
      end
      if (wr_en) wptr_d = wptr_q + PW'(1);
      if (pop)   rptr_d = rptr_q + PW'(1);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        phase_q <= 1'b0;
        lo_q    <= '0;
        wptr_q  <= '0;
        rptr_q  <= '0;
      end else begin
        phase_q <= phase_d;
        lo_q    <= lo_d;
        wptr_q  <= wptr_d;
        rptr_q  <= rptr_d;
      end
    end

    always_ff @(posedge clk) begin
      if (wr_en) mem_q[wptr_q[AW-1:0]] <= {beat, lo_q};
    end

    assign core_data_o[c*WW +: WW] = mem_q[rptr_q[AW-1:0]];
    assign phase_o[c]              = phase_q;
  end

  logic [TW-1:0] tok_cnt_q, tok_cnt_d;
  logic          token_q, token_d;
  logic          ovf_q, ovf_d;

  always_comb begin
    tok_cnt_d = tok_cnt_q;
    token_d   = 1'b0;
    ovf_d     = ovf_q | (|lane_drop);
    if (pop) begin
      if (tok_cnt_q == TW'(TOKEN_DECIM - 1)) begin
        tok_cnt_d = '0;
        token_d   = 1'b1;
      end else begin
        tok_cnt_d = tok_cnt_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tok_cnt_q <= '0;
      token_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      tok_cnt_q <= tok_cnt_d;
      token_q   <= token_d;
      ovf_q     <= ovf_d;
    end
  end

  assign io_token_o = token_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_link_ddr_downstream_multi.sv
// Directed bench for link_ddr_downstream_multi with a scoreboard queue for dequeued words
// and a per-cycle token model.
module tb_link_ddr_downstream_multi;

  logic        clk;
  logic        rst;
  logic [1:0]  io_valid_i;
  logic [15:0] io_data_i;
  logic        core_valid_o;
  logic [31:0] core_data_o;
  logic        core_yumi_i;
  logic        io_token_o;
  logic [1:0]  phase_o;
  logic        overflow_o;

  int checks;
  int passes;
  logic [31:0] sb_q[$];
  logic        mon_en;

  link_ddr_downstream_multi #(
    .CHANNELS(2), .CH_W(8), .DEPTH(4), .TOKEN_DECIM(2)
  ) dut (
    .clk(clk), .rst(rst),
    .io_valid_i(io_valid_i), .io_data_i(io_data_i),
    .core_valid_o(core_valid_o), .core_data_o(core_data_o), .core_yumi_i(core_yumi_i),
    .io_token_o(io_token_o), .phase_o(phase_o), .overflow_o(overflow_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Inputs change 1 time unit after the rising edge and are released after the next one.
  task automatic step(input logic [1:0] v, input logic [7:0] b0, input logic [7:0] b1,
                      input logic y);
    io_valid_i  = v;
    io_data_i   = {b1, b0};
    core_yumi_i = y;
    @(posedge clk);
    #1;
    io_valid_i  = 2'b00;
    core_yumi_i = 1'b0;
  endtask

  // Word layout {lane1 hi, lane1 lo, lane0 hi, lane0 lo}; yumi only on the second beat.
  task automatic send_word(input logic [31:0] w, input logic y);
    step(2'b11, w[7:0],  w[23:16], 1'b0);
    step(2'b11, w[15:8], w[31:24], y);
  endtask

  // Monitor: compares every dequeued word and tracks the expected token per cycle.
  logic       tok_pend;
  logic [0:0] tok_cnt;
  initial begin
    tok_pend = 1'b0;
    tok_cnt  = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (rst) begin
          tok_pend = 1'b0;
          tok_cnt  = 1'b0;
        end else begin
          logic popped;
          popped = core_valid_o & core_yumi_i;
          chk("token", 32'(io_token_o), 32'(tok_pend));
          if (popped) begin
            if (sb_q.size() == 0) chk("sb_underflow", 32'(1), 32'(0));
            else chk("deq_word", core_data_o, sb_q.pop_front());
          end
          tok_pend = popped & (tok_cnt == 1'b1);
          if (popped) tok_cnt = ~tok_cnt;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] w [5];
  logic [3:0]  t4_tok;

  initial begin
    checks = 0; passes = 0; mon_en = 1'b0;
    rst = 1'b1; io_valid_i = '0; io_data_i = '0; core_yumi_i = 1'b0;
    for (int i = 0; i < 5; i++) w[i] = {8'hD0 + 8'(i), 8'hC0 + 8'(i), 8'hB0 + 8'(i), 8'hA0 + 8'(i)};
    step(2'b00, 8'h0, 8'h0, 1'b0);
    step(2'b00, 8'h0, 8'h0, 1'b0);
    chk("rst_valid", 32'(core_valid_o), 32'(0));
    chk("rst_token", 32'(io_token_o), 32'(0));
    chk("rst_phase", 32'(phase_o), 32'(0));
    chk("rst_ovf", 32'(overflow_o), 32'(0));
    rst = 1'b0;
    mon_en = 1'b1;

    // Aligned pair on both lanes.
    step(2'b11, 8'h11, 8'h33, 1'b0);
    chk("t1_phase", 32'(phase_o), 32'(2'b11));
    chk("t1_valid_lo", 32'(core_valid_o), 32'(0));
    step(2'b11, 8'h22, 8'h44, 1'b0);
    chk("t1_valid", 32'(core_valid_o), 32'(1));
    chk("t1_data", core_data_o, 32'h4433_2211);
    sb_q.push_back(32'h4433_2211);
    step(2'b00, 8'h0, 8'h0, 1'b1);
    chk("t1_empty", 32'(core_valid_o), 32'(0));

    // Lane1 skewed 3 cycles behind lane0; word left queued.
    step(2'b01, 8'h55, 8'h0, 1'b0);
    step(2'b01, 8'h66, 8'h0, 1'b0);
    chk("t2_valid_a", 32'(core_valid_o), 32'(0));
    step(2'b00, 8'h0, 8'h0, 1'b0);
    chk("t2_valid_b", 32'(core_valid_o), 32'(0));
    step(2'b10, 8'h0, 8'h77, 1'b0);
    chk("t2_phase", 32'(phase_o), 32'(2'b10));
    chk("t2_valid_c", 32'(core_valid_o), 32'(0));
    step(2'b10, 8'h0, 8'h88, 1'b0);
    chk("t2_valid", 32'(core_valid_o), 32'(1));
    chk("t2_data", core_data_o, 32'h8877_6655);
    sb_q.push_back(32'h8877_6655);

    // Fill to 4 entries, then push into the full FIFO while popping.
    for (int i = 0; i < 3; i++) begin
      send_word(w[i], 1'b0);
      sb_q.push_back(w[i]);
    end
    chk("t5_ovf_before", 32'(overflow_o), 32'(0));
    sb_q.push_back(w[3]);
    send_word(w[3], 1'b1);
    chk("t5_ovf", 32'(overflow_o), 32'(0));
    chk("t5_token", 32'(io_token_o), 32'(1));
    chk("t5_head", core_data_o, w[0]);

    // Full FIFO without a pop: word dropped, overflow sticky, head unchanged.
    send_word(w[4], 1'b0);
    chk("t3_ovf", 32'(overflow_o), 32'(1));
    chk("t3_head", core_data_o, w[0]);
    chk("t3_phase", 32'(phase_o), 32'(0));
    step(2'b00, 8'h0, 8'h0, 1'b0);
    chk("t3_ovf_sticky", 32'(overflow_o), 32'(1));

    // Drain 4 back-to-back pops; token after the 2nd and 4th.
    t4_tok = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step(2'b00, 8'h0, 8'h0, 1'b1);
      chk("t4_token", 32'(io_token_o), 32'(t4_tok[i]));
    end
    chk("t4_empty", 32'(core_valid_o), 32'(0));

    // Reset mid-pair discards the held low half.
    step(2'b01, 8'h99, 8'h0, 1'b0);
    chk("t6_phase", 32'(phase_o), 32'(2'b01));
    rst = 1'b1;
    step(2'b00, 8'h0, 8'h0, 1'b0);
    chk("t6_rst_valid", 32'(core_valid_o), 32'(0));
    chk("t6_rst_token", 32'(io_token_o), 32'(0));
    chk("t6_rst_phase", 32'(phase_o), 32'(0));
    chk("t6_rst_ovf", 32'(overflow_o), 32'(0));
    rst = 1'b0;
    step(2'b11, 8'hAA, 8'hCC, 1'b0);
    step(2'b11, 8'hBB, 8'hDD, 1'b0);
    chk("t6_valid", 32'(core_valid_o), 32'(1));
    chk("t6_lane0", 32'(core_data_o[15:0]), 32'h0000_BBAA);
    sb_q.push_back(32'hDDCC_BBAA);
    step(2'b00, 8'h0, 8'h0, 1'b1);
    step(2'b00, 8'h0, 8'h0, 1'b0);
    chk("sb_drained", 32'(sb_q.size()), 32'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
